// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit.
//   XLEN / INSTR_W : address and instruction widths
//   INSTR_NOP      : canonical no-op encoding (addi x0,x0,0) for downstream bubbles
//   cnt_width()    : width of a counter that must hold 0..depth inclusive
package fetch_pkg;
    localparam int XLEN = 32;
    localparam int INSTR_W = 32;
    localparam logic [INSTR_W-1:0] INSTR_NOP = 32'h0000_0013;

    function automatic int cnt_width(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/instr_fetch_unit_if.sv
// Bus bundle of the fetch unit: instruction-memory request/response channel
// and the valid/ready channel towards decode.
//   master : the fetch unit (drives requests and the decode-side head)
//   slave  : memory plus decode (drives ready, responses and the decode stall)
interface instr_fetch_unit_if;
    import fetch_pkg::*;

    logic               imem_req_valid;
    logic               imem_req_ready;
    logic [XLEN-1:0]    imem_req_addr;
    logic               imem_rsp_valid;
    logic [INSTR_W-1:0] imem_rsp_data;
    logic               if_valid;
    logic               if_ready;
    logic [XLEN-1:0]    if_pc;
    logic [INSTR_W-1:0] if_instr;

    modport master (
        output imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, if_valid, if_pc, if_instr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, if_ready
    );
endinterface

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with push, pop and flush (power-of-two DEPTH).
//   clk, srst          : clock, synchronous active-high reset
//   flush              : empties the FIFO at the edge; overrides push/pop
//   push, push_data    : write one entry at the tail
//   pop                : drop the head entry
//   head_data          : current head (meaningless while count == 0)
//   count              : number of entries held, 0..DEPTH
// The caller guarantees no push when full and no pop when empty.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        flush,
    input  logic                        push,
    input  logic [WIDTH-1:0]            push_data,
    input  logic                        pop,
    output logic [WIDTH-1:0]            head_data,
    output logic [cnt_width(DEPTH)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = cnt_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW-1:0]    wr_ptr_reg;
    logic [CW-1:0]    count_reg;

    // Storage is not reset; entries only become visible through count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= push_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + AW'(1);
            end
            count_reg <= count_reg + CW'(push) - CW'(pop);
        end
    end

    assign head_data = mem[rd_ptr_reg];
    assign count     = count_reg;
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: issues sequential word fetches to a variable-latency memory,
// pairs in-order responses with their PCs, buffers them in a prefetch queue
// and hands them to decode. A redirect flushes the queue and discards the
// responses still in flight.
//   clk, reset      : clock, synchronous active-high reset
//   redirect_valid  : taken branch from EX this cycle
//   redirect_pc     : branch target (low two bits ignored)
//   bus (master)    : imem request/response channel and decode channel
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
    parameter int              DEPTH    = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    instr_fetch_unit_if.master bus
);
    localparam int CW = cnt_width(DEPTH);
    localparam int QW = XLEN + INSTR_W;

    logic [XLEN-1:0] fetch_pc_reg;
    logic [CW-1:0]   outstanding_reg;
    logic [CW-1:0]   discard_reg;

    logic [CW-1:0]   q_count;
    logic [QW-1:0]   q_head;
    logic [CW-1:0]   pcq_count;
    logic [XLEN-1:0] pcq_head;
    logic [CW:0]     in_use;
    logic            req_fire;
    logic            rsp_accept;
    logic            rsp_keep;
    logic            pop;

    // Queued entries plus requests in flight may never exceed DEPTH, which
    // reserves a queue slot for every response before it is requested.
    assign in_use   = {1'b0, q_count} + {1'b0, outstanding_reg};
    assign bus.imem_req_valid = !reset && !redirect_valid && (in_use < (CW+1)'(DEPTH));
    assign bus.imem_req_addr  = fetch_pc_reg;
    assign req_fire = bus.imem_req_valid && bus.imem_req_ready;

    // A response with nothing outstanding is a protocol error and is ignored.
    assign rsp_accept = bus.imem_rsp_valid && (outstanding_reg != '0);
    // Responses owed to a redirected path, or arriving with a redirect, are dropped.
    assign rsp_keep   = rsp_accept && (discard_reg == '0) && !redirect_valid;

    assign pop = bus.if_valid && bus.if_ready;

    // PCs of live (non-discarded) requests in issue order.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(XLEN)) u_pc_fifo (
        .clk       (clk),
        .srst      (reset),
        .flush     (redirect_valid),
        .push      (req_fire),
        .push_data (fetch_pc_reg),
        .pop       (rsp_keep && (pcq_count != '0)),
        .head_data (pcq_head),
        .count     (pcq_count)
    );

    // Prefetch queue of {pc, instr}.
    fetch_fifo #(.DEPTH(DEPTH), .WIDTH(QW)) u_instr_queue (
        .clk       (clk),
        .srst      (reset),
        .flush     (redirect_valid),
        .push      (rsp_keep),
        .push_data ({pcq_head, bus.imem_rsp_data}),
        .pop       (pop),
        .head_data (q_head),
        .count     (q_count)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_pc_reg    <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            outstanding_reg <= outstanding_reg + CW'(req_fire) - CW'(rsp_accept);
            if (redirect_valid) begin
                // No request fires this cycle, so every request still owed
                // (less the one answered now) belongs to the old path.
                fetch_pc_reg <= redirect_pc & ~XLEN'(3);
                discard_reg  <= outstanding_reg - CW'(rsp_accept);
            end else begin
                if (req_fire) begin
                    fetch_pc_reg <= fetch_pc_reg + XLEN'(4);
                end
                if (rsp_accept && (discard_reg != '0)) begin
                    discard_reg <= discard_reg - CW'(1);
                end
            end
        end
    end

    // Head is forced to zero while empty so the outputs are defined after reset.
    assign bus.if_valid = (q_count != '0);
    assign bus.if_pc    = bus.if_valid ? q_head[QW-1:INSTR_W] : '0;
    assign bus.if_instr = bus.if_valid ? q_head[INSTR_W-1:0]  : '0;

    always @(posedge clk) begin
        if (!reset) begin
            assert (!(bus.imem_rsp_valid && (outstanding_reg == '0)))
                else $error("instr_fetch_unit: response received with no request outstanding");
        end
    end
endmodule
